// File: rtl/hacd_pkg.sv
// hacd_pkg: shared types and constants for the AXI read downsizer.
// Provides the FSM state enum, default widths, AXI encodings and resp merge.
package hacd_pkg;

    localparam int         HACD_S_DW       = 512;
    localparam int         HACD_M_DW       = 256;
    localparam logic [2:0] HACD_M_ARSIZE   = 3'd5;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAR  = 2'd1,
        DATA = 2'd2,
        ERR  = 2'd3
    } hacd_state_e;

    // Worst of two AXI responses (higher code is more severe).
    function automatic logic [1:0] resp_max(
        input logic [1:0] a,
        input logic [1:0] b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hawk_axi_rd_dwnszr.sv
// hawk_axi_rd_dwnszr: single-outstanding AXI read downsizer, S_DW -> M_DW.
// Ports: clk/rst; s_axi_ar*/s_axi_r* upstream slave; m_axi_ar*/m_axi_r* to the
// memory controller; proto_err sticky flag for memory-controller rlast misuse.
// S_DW is expected to be exactly 2*M_DW.
module hawk_axi_rd_dwnszr
    import hacd_pkg::*;
#(
    parameter int ID_W   = 6,
    parameter int ADDR_W = 64,
    parameter int S_DW   = HACD_S_DW,
    parameter int M_DW   = HACD_M_DW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ID_W-1:0]   s_axi_arid,
    input  logic [ADDR_W-1:0] s_axi_araddr,
    input  logic [7:0]        s_axi_arlen,
    input  logic [2:0]        s_axi_arsize,
    input  logic [1:0]        s_axi_arburst,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    output logic [ID_W-1:0]   s_axi_rid,
    output logic [S_DW-1:0]   s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rlast,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,
    output logic [ID_W-1:0]   m_axi_arid,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [7:0]        m_axi_arlen,
    output logic [2:0]        m_axi_arsize,
    output logic [1:0]        m_axi_arburst,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [ID_W-1:0]   m_axi_rid,
    input  logic [M_DW-1:0]   m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rlast,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready,
    output logic              proto_err
);

    hacd_state_e       state_q,     state_d;
    logic [ID_W-1:0]   id_q,        id_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic [7:0]        len_q,       len_d;
    logic              half_q,      half_d;
    logic [7:0]        beat_q,      beat_d;
    logic [M_DW-1:0]   lo_q,        lo_d;
    logic [1:0]        lo_resp_q,   lo_resp_d;
    logic [S_DW-1:0]   out_data_q,  out_data_d;
    logic [1:0]        out_resp_q,  out_resp_d;
    logic              out_last_q,  out_last_d;
    logic              out_valid_q, out_valid_d;
    logic              perr_q,      perr_d;

    logic s_fire;
    logic m_fire;
    logic last_pair;
    logic out_done;
    logic out_free;
    logic in_mar;
    logic unused_ok;

    // Burst size/type are implied by the cacheline path; MC rid is not trusted.
    assign unused_ok = ^{s_axi_arsize, s_axi_arburst, m_axi_rid};

    assign in_mar    = (state_q == MAR);
    assign s_fire    = out_valid_q & s_axi_rready;
    assign m_fire    = m_axi_rvalid & m_axi_rready;
    assign last_pair = (beat_q == len_q);
    // Final beat already staged: nothing more may be loaded this burst.
    assign out_done  = out_valid_q & out_last_q;
    assign out_free  = ~out_valid_q | s_axi_rready;

    assign s_axi_arready = (state_q == IDLE) & ~rst;
    assign s_axi_rid     = id_q;
    assign s_axi_rdata   = out_data_q;
    assign s_axi_rresp   = out_resp_q;
    assign s_axi_rlast   = out_last_q;
    assign s_axi_rvalid  = out_valid_q;

    assign m_axi_arvalid = in_mar;
    assign m_axi_arid    = in_mar ? id_q : '0;
    assign m_axi_araddr  = in_mar ? addr_q : '0;
    assign m_axi_arlen   = in_mar ? {len_q[6:0], 1'b1} : 8'd0;
    assign m_axi_arsize  = in_mar ? HACD_M_ARSIZE : 3'd0;
    assign m_axi_arburst = in_mar ? AXI_BURST_INCR : 2'd0;
    assign m_axi_rready  = (state_q == DATA) & out_free;

    assign proto_err = perr_q;

    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        addr_d      = addr_q;
        len_d       = len_q;
        half_d      = half_q;
        beat_d      = beat_q;
        lo_d        = lo_q;
        lo_resp_d   = lo_resp_q;
        out_data_d  = out_data_q;
        out_resp_d  = out_resp_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;
        perr_d      = perr_q;

        if (s_fire) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (s_axi_arvalid) begin
                    id_d    = s_axi_arid;
                    addr_d  = s_axi_araddr;
                    len_d   = s_axi_arlen;
                    beat_d  = 8'd0;
                    half_d  = 1'b0;
                    state_d = s_axi_arlen[7] ? ERR : MAR;
                end
            end
            MAR: begin
                if (m_axi_arready) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (m_fire) begin
                    if (!half_q) begin
                        lo_d      = m_axi_rdata;
                        lo_resp_d = m_axi_rresp;
                        half_d    = 1'b1;
                        if (m_axi_rlast) begin
                            perr_d = 1'b1;
                        end
                    end else begin
                        out_data_d  = {m_axi_rdata, lo_q};
                        out_resp_d  = resp_max(lo_resp_q, m_axi_rresp);
                        out_last_d  = last_pair;
                        out_valid_d = 1'b1;
                        beat_d      = beat_q + 8'd1;
                        half_d      = 1'b0;
                        if (last_pair && !m_axi_rlast) begin
                            perr_d = 1'b1;
                        end
                    end
                end
                if (s_fire && out_last_q) begin
                    state_d = IDLE;
                    beat_d  = 8'd0;
                    half_d  = 1'b0;
                end
            end
            ERR: begin
                if (out_free && !out_done) begin
                    out_data_d  = '0;
                    out_resp_d  = AXI_RESP_SLVERR;
                    out_last_d  = last_pair;
                    out_valid_d = 1'b1;
                    beat_d      = beat_q + 8'd1;
                end
                if (s_fire && out_last_q) begin
                    state_d = IDLE;
                    beat_d  = 8'd0;
                    half_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            id_q        <= '0;
            addr_q      <= '0;
            len_q       <= 8'd0;
            half_q      <= 1'b0;
            beat_q      <= 8'd0;
            lo_q        <= '0;
            lo_resp_q   <= 2'd0;
            out_data_q  <= '0;
            out_resp_q  <= 2'd0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            perr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            half_q      <= half_d;
            beat_q      <= beat_d;
            lo_q        <= lo_d;
            lo_resp_q   <= lo_resp_d;
            out_data_q  <= out_data_d;
            out_resp_q  <= out_resp_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
            perr_q      <= perr_d;
        end
    end

endmodule

// File: tb/tb_hawk_axi_rd_dwnszr.sv
// tb_hawk_axi_rd_dwnszr: randomized scoreboard bench for the read downsizer.
// Expected upstream beats are built from the MC beat list and pushed on issue.
module tb_hawk_axi_rd_dwnszr;
    import hacd_pkg::*;

    localparam int ID_W   = 6;
    localparam int ADDR_W = 64;
    localparam int S_DW   = 512;
    localparam int M_DW   = 256;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [ID_W-1:0]   s_axi_arid = '0;
    logic [ADDR_W-1:0] s_axi_araddr = '0;
    logic [7:0]        s_axi_arlen = '0;
    logic [2:0]        s_axi_arsize = '0;
    logic [1:0]        s_axi_arburst = '0;
    logic              s_axi_arvalid = 1'b0;
    logic              s_axi_arready;
    logic [ID_W-1:0]   s_axi_rid;
    logic [S_DW-1:0]   s_axi_rdata;
    logic [1:0]        s_axi_rresp;
    logic              s_axi_rlast;
    logic              s_axi_rvalid;
    logic              s_axi_rready = 1'b0;
    logic [ID_W-1:0]   m_axi_arid;
    logic [ADDR_W-1:0] m_axi_araddr;
    logic [7:0]        m_axi_arlen;
    logic [2:0]        m_axi_arsize;
    logic [1:0]        m_axi_arburst;
    logic              m_axi_arvalid;
    logic              m_axi_arready = 1'b0;
    logic [ID_W-1:0]   m_axi_rid = '0;
    logic [M_DW-1:0]   m_axi_rdata = '0;
    logic [1:0]        m_axi_rresp = '0;
    logic              m_axi_rlast = 1'b0;
    logic              m_axi_rvalid = 1'b0;
    logic              m_axi_rready;
    logic              proto_err;

    always #5 clk = ~clk;

    hawk_axi_rd_dwnszr #(
        .ID_W(ID_W), .ADDR_W(ADDR_W), .S_DW(S_DW), .M_DW(M_DW)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr),
        .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize),
        .s_axi_arburst(s_axi_arburst), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata),
        .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr),
        .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
        .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata),
        .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .proto_err(proto_err)
    );

    typedef struct {
        logic [S_DW-1:0] data;
        logic [1:0]      resp;
        logic            last;
        logic [ID_W-1:0] id;
    } sbeat_t;

    sbeat_t exp_q[$];
    sbeat_t mon_e;
    int     n_tests = 0;
    int     n_fail  = 0;
    logic   exp_perr = 1'b0;
    bit     bp_en = 1'b0;
    bit     gap_en = 1'b0;
    int     hold_at = -1;
    int     hold_left = 0;
    int     up_cnt = 0;
    int     cyc = 0;
    int     first_hs = -1;
    int     last_hs = -1;
    int     arv_cyc = 0;

    task automatic chk(input string nm, input logic [S_DW-1:0] act,
                       input logic [S_DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Upstream R backpressure: random, or a deterministic 5-cycle hold.
    always @(posedge clk) begin
        #1;
        if (hold_left > 0) begin
            s_axi_rready = 1'b0;
            hold_left--;
        end else if (hold_at >= 0 && up_cnt == hold_at) begin
            s_axi_rready = 1'b0;
            hold_left = 4;
            hold_at = -1;
        end else begin
            s_axi_rready = bp_en ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    // Monitor: a handshake seen here completes on the next rising edge.
    always @(negedge clk) begin
        if (!rst && m_axi_arvalid) arv_cyc++;
        if (!rst && s_axi_rvalid && s_axi_rready) begin
            up_cnt++;
            if (first_hs < 0) first_hs = cyc;
            last_hs = cyc;
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", S_DW'(1), S_DW'(0));
            end else begin
                mon_e = exp_q.pop_front();
                chk("rdata", s_axi_rdata, mon_e.data);
                chk("rresp", S_DW'(s_axi_rresp), S_DW'(mon_e.resp));
                chk("rlast", S_DW'(s_axi_rlast), S_DW'(mon_e.last));
                chk("rid", S_DW'(s_axi_rid), S_DW'(mon_e.id));
            end
        end
    end

    // mode: 0 clean, 1 rlast on first MC beat.
    // rmode: 0 random resp, 1 all OKAY, 2 OKAY then SLVERR on first pair.
    task automatic run_txn(input logic [7:0] len, input logic [ADDR_W-1:0] addr,
                           input int mode, input int rmode);
        logic [M_DW-1:0] md[$];
        logic [1:0]      mr[$];
        logic            ml[$];
        logic [ID_W-1:0] id;
        logic [1:0]      ra;
        logic [1:0]      rb;
        sbeat_t          e;
        int              nb;
        int              ups;
        int              arv0;
        int              ta;
        int              tb;
        int              tc;
        int              i;
        id   = ID_W'($urandom);
        ups  = int'(len) + 1;
        nb   = len[7] ? 0 : 2 * ups;
        arv0 = arv_cyc;
        first_hs = -1;
        for (int k = 0; k < nb; k++) begin
            md.push_back({$urandom, $urandom, $urandom, $urandom,
                          $urandom, $urandom, $urandom, $urandom});
            if (rmode == 1) mr.push_back(AXI_RESP_OKAY);
            else if (rmode == 2) mr.push_back(k == 1 ? AXI_RESP_SLVERR : AXI_RESP_OKAY);
            else mr.push_back(($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0);
            ml.push_back(k == nb - 1);
        end
        if (mode == 1 && nb > 0) begin
            ml[0] = 1'b1;
            exp_perr = 1'b1;
        end
        for (int k = 0; k < ups; k++) begin
            e.id   = id;
            e.last = (k == ups - 1);
            if (len[7]) begin
                e.data = '0;
                e.resp = AXI_RESP_SLVERR;
            end else begin
                e.data = {md[2*k+1], md[2*k]};
                ra = mr[2*k];
                rb = mr[2*k+1];
                e.resp = (ra > rb) ? ra : rb;
            end
            exp_q.push_back(e);
        end
        ta = 0; tb = 0; tc = 0;
        fork
            begin
                @(posedge clk); #1;
                s_axi_arvalid = 1'b1;
                s_axi_arid    = id;
                s_axi_araddr  = addr;
                s_axi_arlen   = len;
                s_axi_arsize  = 3'd6;
                s_axi_arburst = AXI_BURST_INCR;
                @(negedge clk);
                while (!s_axi_arready && ta < 100) begin
                    @(negedge clk);
                    ta++;
                end
                chk("s_arready_seen", S_DW'(s_axi_arready), S_DW'(1));
                @(posedge clk); #1;
                s_axi_arvalid = 1'b0;
            end
            begin
                if (nb > 0) begin
                    while (tb < 200) begin
                        @(posedge clk); #1;
                        m_axi_arready = 1'($urandom_range(0, 1));
                        @(negedge clk);
                        if (m_axi_arvalid && m_axi_arready) break;
                        tb++;
                    end
                    chk("m_ar_handshake", S_DW'(m_axi_arvalid && m_axi_arready), S_DW'(1));
                    chk("m_arlen", S_DW'(m_axi_arlen), S_DW'(nb - 1));
                    chk("m_arsize", S_DW'(m_axi_arsize), S_DW'(5));
                    chk("m_arburst", S_DW'(m_axi_arburst), S_DW'(AXI_BURST_INCR));
                    chk("m_araddr", S_DW'(m_axi_araddr), S_DW'(addr));
                    chk("m_arid", S_DW'(m_axi_arid), S_DW'(id));
                    @(posedge clk); #1;
                    m_axi_arready = 1'b0;
                    i = 0;
                    tb = 0;
                    while (i < nb && tb < 5000) begin
                        m_axi_rvalid = gap_en ? ($urandom_range(0, 3) != 0) : 1'b1;
                        m_axi_rdata  = md[i];
                        m_axi_rresp  = mr[i];
                        m_axi_rlast  = ml[i];
                        m_axi_rid    = ID_W'($urandom);
                        @(negedge clk);
                        if (m_axi_rvalid && m_axi_rready) i++;
                        @(posedge clk); #1;
                        tb++;
                    end
                    m_axi_rvalid = 1'b0;
                    m_axi_rlast  = 1'b0;
                    chk("mc_beats_taken", S_DW'(i), S_DW'(nb));
                end
            end
            begin
                while (exp_q.size() != 0 && tc < 20000) begin
                    @(posedge clk);
                    tc++;
                end
                chk("txn_complete", S_DW'(exp_q.size()), S_DW'(0));
                exp_q.delete();
            end
        join
        repeat (3) @(posedge clk);
        #1;
        if (nb == 0) chk("no_m_arvalid", S_DW'(arv_cyc - arv0), S_DW'(0));
        chk("proto_err", S_DW'(proto_err), S_DW'(exp_perr));
    endtask

    initial begin
        logic [7:0] rl;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s_rvalid", S_DW'(s_axi_rvalid), S_DW'(0));
        chk("rst_m_arvalid", S_DW'(m_axi_arvalid), S_DW'(0));
        chk("rst_m_rready", S_DW'(m_axi_rready), S_DW'(0));
        chk("rst_proto_err", S_DW'(proto_err), S_DW'(0));
        chk("rst_rdata", s_axi_rdata, S_DW'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_arready", S_DW'(s_axi_arready), S_DW'(1));

        run_txn(8'd0, 64'h1000, 0, 1);
        run_txn(8'd0, 64'h2000, 0, 2);
        hold_at = 2;
        up_cnt = 0;
        run_txn(8'd3, 64'h3000, 0, 0);
        run_txn(8'd7, 64'h4000, 0, 0);
        chk("throughput", S_DW'(last_hs - first_hs), S_DW'(14));
        bp_en = 1'b1;
        gap_en = 1'b1;
        run_txn(8'h80, 64'h5000, 0, 0);
        run_txn(8'd1, 64'h6000, 1, 0);
        run_txn(8'd2, 64'h7000, 0, 0);
        for (int n = 0; n < 20; n++) begin
            bp_en  = 1'($urandom_range(0, 1));
            gap_en = 1'($urandom_range(0, 1));
            rl = ($urandom_range(0, 9) == 0) ? (8'h80 | 8'($urandom_range(0, 5)))
                                             : 8'($urandom_range(0, 15));
            run_txn(rl, {$urandom, $urandom}, 0, 0);
        end

        // Reset while a pair is half-collected in DATA.
        bp_en = 1'b0;
        @(posedge clk); #1;
        s_axi_arvalid = 1'b1;
        s_axi_arid    = 6'h15;
        s_axi_araddr  = 64'h8000;
        s_axi_arlen   = 8'd3;
        @(posedge clk); #1;
        s_axi_arvalid = 1'b0;
        m_axi_arready = 1'b1;
        @(posedge clk); #1;
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b1;
        m_axi_rdata   = {8{32'hdead_beef}};
        @(negedge clk);
        chk("mid_m_rready", S_DW'(m_axi_rready), S_DW'(1));
        @(posedge clk); #1;
        m_axi_rvalid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_perr = 1'b0;
        @(negedge clk);
        chk("mid_rst_arready", S_DW'(s_axi_arready), S_DW'(1));
        chk("mid_rst_rvalid", S_DW'(s_axi_rvalid), S_DW'(0));
        chk("mid_rst_m_rready", S_DW'(m_axi_rready), S_DW'(0));
        chk("mid_rst_proto_err", S_DW'(proto_err), S_DW'(0));
        run_txn(8'd1, 64'h9000, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hawk_axi_rd_dwnszr.md
HAWK_AXI_RD_DWNSZR -- requirements
Module: hawk_axi_rd_dwnszr

Interface
REQ-001 SHALL have parameter ID_W, default 6, meaning the AXI ID width on both sides.
REQ-002 SHALL have parameter ADDR_W, default 64, meaning the AXI address width.
REQ-003 SHALL have parameter S_DW, default 512, meaning the upstream (cacheline) data width.
REQ-004 SHALL have parameter M_DW, default 256, meaning the memory-controller data width; S_DW SHALL equal 2*M_DW.
REQ-005 SHALL use one clock and a synchronous, active-high reset; clk and rst are listed first.
REQ-006 clk  in  1  sole clock.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 s_axi_arid/araddr/arlen/arsize/arburst/arvalid  in  ID_W/ADDR_W/8/3/2/1  upstream read address.
REQ-009 s_axi_arready  out  1  upstream address accept.
REQ-010 s_axi_rid/rdata/rresp/rlast/rvalid  out  ID_W/S_DW/2/1/1  upstream read data.
REQ-011 s_axi_rready  in  1  upstream data accept.
REQ-012 m_axi_arid/araddr/arlen/arsize/arburst/arvalid  out  ID_W/ADDR_W/8/3/2/1  address toward the memory controller.
REQ-013 m_axi_arready  in  1  memory-controller address accept.
REQ-014 m_axi_rid/rdata/rresp/rlast/rvalid  in  ID_W/M_DW/2/1/1  memory-controller read data.
REQ-015 m_axi_rready  out  1  memory-controller data accept.
REQ-016 proto_err  out  1  sticky flag for a memory-controller protocol violation.

Function
REQ-017 SHALL have FSM states IDLE, MAR, DATA, ERR; exactly one transaction is outstanding at a time.
REQ-018 s_axi_arready SHALL be 1 only in IDLE; on the s_axi_arvalid&arready handshake, arid, araddr and arlen SHALL be latched.
REQ-019 On that handshake: if s_axi_arlen[7]==0, the next state SHALL be MAR; otherwise the next state SHALL be ERR.
REQ-020 In MAR, m_axi_arvalid SHALL be 1 with:
  - araddr = latched address;
  - arlen = {latched_len[6:0],1'b1};
  - arsize = 3'd5;
  - arburst = INCR;
  - arid = latched id.
  On m_axi_arready the state SHALL become DATA; m_axi_arvalid SHALL rise the cycle after the upstream handshake.
REQ-021 In DATA, a half-counter (0/1) SHALL toggle on each m_axi_rvalid&rready.
  - Half 0 SHALL load the low pack register.
  - Half 1 SHALL form {m_rdata, low} into the output register and set out_valid.
REQ-022 m_axi_rready SHALL be (state==DATA) & (!out_valid | s_axi_rready); the block SHALL NOT drop or duplicate a beat under any backpressure.
REQ-023 s_axi_rresp SHALL be the numerically larger of the two half responses.
REQ-024 s_axi_rid SHALL be the latched id; m_axi_rid SHALL be ignored.
REQ-025 s_axi_rlast SHALL be 1 when the upstream beat count equals the latched len.
REQ-026 After the s_axi_rlast handshake, the state SHALL return to IDLE and the beat count and half-counter SHALL clear.
REQ-027 If m_axi_rlast is seen on half 0, or is absent on the final half-1 beat, proto_err SHALL set and hold until rst; the transfer SHALL otherwise complete by count.
REQ-028 In ERR, the block SHALL return latched_len+1 beats of zero data with rresp=SLVERR and rlast on the final beat, with no request to the memory controller, then return to IDLE.
REQ-029 Throughput SHALL be one upstream beat per two memory-controller beats when there is no backpressure.

Reset
REQ-030 With rst high, at the next edge:
  - state SHALL be IDLE;
  - counters, out_valid and proto_err SHALL be 0;
  - all valid/ready outputs SHALL be 0, except s_axi_arready, which SHALL be 1 after reset release;
  - data outputs SHALL be 0.
REQ-031 rst asserted mid-transfer SHALL abandon the transfer; stale memory-controller beats after reset are excluded by system contract (the block is reset together with its read master).

Structure
REQ-032 The state enum typedef and the width constants (512/256, arsize 3'd5) SHALL reside in hacd_pkg.
REQ-033 No sub-module: the pack and output registers are inline.

Verification
REQ-034 Upstream arlen=0 at addr 0x1000: m_arlen=1, arsize=5; MC beats A,B produce one s beat {B,A} with rlast=1, rresp=OKAY.
REQ-035 Upstream arlen=3 with s_axi_rready held low for 5 cycles on beat 2: 8 MC beats become 4 intact 512-bit beats, with no beat lost.
REQ-036 MC responses OKAY then SLVERR on the same pair: that upstream beat has rresp=SLVERR.
REQ-037 Upstream arlen=0x80: no m_arvalid; 129 zero beats with SLVERR, the last with rlast=1.
REQ-038 MC asserts rlast on beat 1 of 4: proto_err=1, the transfer still completes, and proto_err stays 1 until rst.
REQ-039 rst asserted in DATA after one MC beat: the next cycle shows IDLE, s_arready=1, out_valid=0.
